// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter for the instruction and data ports. Data has priority,
// each grant is bounded by a timeout, and RAM faults raise a sticky memerr flag.
module memory_arbiter #(
  parameter int          TIMEOUT = 255,
  parameter logic [31:0] ERRWORD = 32'hBAD1BAD1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        memerr
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    IGRANT = 3'd1,
    DGRANT = 3'd2,
    IDONE  = 3'd3,
    DDONE  = 3'd4
  } state_t;

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;
  localparam logic [9:0] TLAST      = 10'(TIMEOUT - 1);

  state_t      state_r;
  logic        op_write_r;
  logic [9:0]  tcount_r;
  logic        access_s;
  logic        fault_s;

  // Grant termination decode; ACCESS takes precedence over an expiring timeout
  always_comb begin
    access_s = 1'b0;
    fault_s  = 1'b0;
    if (ramstate == RAM_ACCESS) begin
      access_s = 1'b1;
    end else if (ramstate == RAM_ERROR || tcount_r == TLAST) begin
      fault_s = 1'b1;
    end else begin
      fault_s = 1'b0;
    end
  end

  // Completion pulses decoded from the DONE states, qualified by a live request
  assign iwait = !(state_r == IDONE && iREN);
  assign dwait = !(state_r == DDONE && (dREN || dWEN));

  // Arbitration FSM with registered RAM strobes, latched address/data and load words
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r    <= IDLE;
      op_write_r <= 1'b0;
      tcount_r   <= 10'd0;
      ramREN     <= 1'b0;
      ramWEN     <= 1'b0;
      ramaddr    <= 32'd0;
      ramstore   <= 32'd0;
      iload      <= 32'd0;
      dload      <= 32'd0;
      memerr     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (dREN || dWEN) begin
            ramaddr    <= daddr;
            ramstore   <= dstore;
            op_write_r <= dWEN;
            ramWEN     <= dWEN;
            ramREN     <= !dWEN;
            tcount_r   <= 10'd0;
            state_r    <= DGRANT;
          end else if (iREN) begin
            ramaddr  <= iaddr;
            ramREN   <= 1'b1;
            ramWEN   <= 1'b0;
            tcount_r <= 10'd0;
            state_r  <= IGRANT;
          end else begin
            ramREN <= 1'b0;
            ramWEN <= 1'b0;
          end
        end
        IGRANT: begin
          if (access_s) begin
            iload   <= ramload;
            ramREN  <= 1'b0;
            ramWEN  <= 1'b0;
            state_r <= IDONE;
          end else if (fault_s) begin
            iload   <= ERRWORD;
            memerr  <= 1'b1;
            ramREN  <= 1'b0;
            ramWEN  <= 1'b0;
            state_r <= IDONE;
          end else begin
            tcount_r <= tcount_r + 10'd1;
          end
        end
        DGRANT: begin
          if (access_s) begin
            if (!op_write_r) begin
              dload <= ramload;
            end
            ramREN  <= 1'b0;
            ramWEN  <= 1'b0;
            state_r <= DDONE;
          end else if (fault_s) begin
            if (!op_write_r) begin
              dload <= ERRWORD;
            end
            memerr  <= 1'b1;
            ramREN  <= 1'b0;
            ramWEN  <= 1'b0;
            state_r <= DDONE;
          end else begin
            tcount_r <= tcount_r + 10'd1;
          end
        end
        IDONE, DDONE: begin
          ramREN  <= 1'b0;
          ramWEN  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          ramREN  <= 1'b0;
          ramWEN  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: a small reference model pushes expected
// completions to a scoreboard that is popped when a wait pulse appears.
module tb_memory_arbiter;

  localparam int          TMO  = 4;
  localparam logic [31:0] ERRW = 32'hBAD1BAD1;
  localparam logic [1:0]  FREE = 2'd0;
  localparam logic [1:0]  BUSY = 2'd1;
  localparam logic [1:0]  ACC  = 2'd2;
  localparam logic [1:0]  ERR  = 2'd3;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN, memerr;
  logic [31:0] iload, dload, ramaddr, ramstore;

  always #5 CLK = ~CLK;

  memory_arbiter #(.TIMEOUT(TMO), .ERRWORD(ERRW)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .memerr(memerr)
  );

  typedef struct {
    logic        is_d;
    logic [31:0] iload;
    logic [31:0] dload;
    logic        err;
    int          cycles;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          passes = 0;
  logic [31:0] iload_m = 32'd0;
  logic [31:0] dload_m = 32'd0;
  logic [31:0] store_m = 32'd0;
  logic        memerr_m = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  // Drives one request at a negedge in IDLE and follows it to its completion pulse.
  task automatic access(input logic ir, input logic dr, input logic dw,
                        input logic [31:0] ia, input logic [31:0] da,
                        input logic [31:0] ds, input logic [31:0] rl,
                        input logic [1:0] fin, input int nbusy);
    exp_t e;
    logic is_d, wr, err, tmo, done;
    int   ncyc, k;
    is_d = dr | dw;
    wr   = dw;
    tmo  = (nbusy >= TMO);
    err  = tmo || (fin == ERR);
    ncyc = tmo ? TMO : nbusy + 1;
    if (is_d) begin
      store_m = ds;
      if (!wr) dload_m = err ? ERRW : rl;
    end else begin
      iload_m = err ? ERRW : rl;
    end
    memerr_m = memerr_m | err;
    e = '{is_d, iload_m, dload_m, memerr_m, ncyc};
    sb.push_back(e);

    iREN = ir; dREN = dr; dWEN = dw;
    iaddr = ia; daddr = da; dstore = ds; ramload = rl; ramstate = FREE;
    k = 0;
    done = 1'b0;
    while (!done && k < 20) begin
      @(negedge CLK);
      k++;
      if (!iwait || !dwait) begin
        done = 1'b1;
      end else begin
        chk1("grant_ramREN", ramREN, is_d ? !wr : 1'b1);
        chk1("grant_ramWEN", ramWEN, is_d & wr);
        chk("grant_ramaddr", ramaddr, is_d ? da : ia);
        chk("grant_ramstore", ramstore, store_m);
        ramstate = (k <= nbusy) ? BUSY : fin;
      end
    end
    e = sb.pop_front();
    chk1("done_seen", done, 1'b1);
    if (done) begin
      chk("done_cycle", k, e.cycles + 1);
      chk1("done_iwait", iwait, e.is_d);
      chk1("done_dwait", dwait, !e.is_d);
      chk("done_iload", iload, e.iload);
      chk("done_dload", dload, e.dload);
      chk1("done_memerr", memerr, e.err);
      chk1("done_ramREN", ramREN, 1'b0);
      chk1("done_ramWEN", ramWEN, 1'b0);
      if (e.is_d) begin
        dREN = 1'b0;
        dWEN = 1'b0;
      end else begin
        iREN = 1'b0;
      end
      ramstate = FREE;
      @(negedge CLK);
      chk1("idle_iwait", iwait, 1'b1);
      chk1("idle_dwait", dwait, 1'b1);
      chk1("idle_ramREN", ramREN, 1'b0);
      chk1("idle_ramWEN", ramWEN, 1'b0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = 32'd0; daddr = 32'd0; dstore = 32'd0; ramload = 32'd0; ramstate = FREE;
    #1;
    chk1("rst_iwait", iwait, 1'b1);
    chk1("rst_dwait", dwait, 1'b1);
    chk1("rst_ramREN", ramREN, 1'b0);
    chk1("rst_ramWEN", ramWEN, 1'b0);
    chk("rst_ramaddr", ramaddr, 32'd0);
    chk("rst_iload", iload, 32'd0);
    chk1("rst_memerr", memerr, 1'b0);
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);

    // Instruction fetch with one BUSY cycle
    access(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 32'h8C220004, ACC, 1);
    // Simultaneous requests: data first, instruction right after one IDLE cycle
    access(1'b1, 1'b1, 1'b0, 32'h44, 32'h100, 32'h0, 32'h11112222, ACC, 0);
    access(1'b1, 1'b0, 1'b0, 32'h44, 32'h100, 32'h0, 32'h33334444, ACC, 0);
    // Both strobes high is a write; dload must not change
    access(1'b0, 1'b1, 1'b1, 32'h0, 32'h200, 32'hDEADBEEF, 32'h55555555, ACC, 0);
    // ACCESS on the last timeout cycle wins without error
    access(1'b0, 1'b1, 1'b0, 32'h0, 32'h300, 32'h0, 32'h12345678, ACC, 3);
    // RAM error on an instruction fetch, then a good access keeps memerr high
    access(1'b1, 1'b0, 1'b0, 32'h80, 32'h0, 32'h0, 32'h0F0F0F0F, ERR, 1);
    access(1'b0, 1'b1, 1'b0, 32'h0, 32'h400, 32'h0, 32'hCAFEF00D, ACC, 0);
    // Data read held BUSY until the timeout forces completion
    access(1'b0, 1'b1, 1'b0, 32'h0, 32'h500, 32'h0, 32'h00000099, BUSY, 10);

    // Reset in the middle of a data grant
    dREN = 1'b1; dWEN = 1'b0; daddr = 32'h700; ramstate = BUSY;
    @(negedge CLK);
    chk1("pre_rst_ramREN", ramREN, 1'b1);
    @(negedge CLK);
    nRST = 1'b0;
    #1;
    iload_m = 32'd0; dload_m = 32'd0; store_m = 32'd0; memerr_m = 1'b0;
    chk1("mid_rst_ramREN", ramREN, 1'b0);
    chk("mid_rst_ramaddr", ramaddr, 32'd0);
    chk("mid_rst_ramstore", ramstore, store_m);
    chk("mid_rst_dload", dload, dload_m);
    chk("mid_rst_iload", iload, iload_m);
    chk1("mid_rst_memerr", memerr, memerr_m);
    chk1("mid_rst_dwait", dwait, 1'b1);
    dREN = 1'b0; ramstate = FREE;
    @(negedge CLK);
    nRST = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk1("post_rst_dwait", dwait, 1'b1);
      chk1("post_rst_ramREN", ramREN, 1'b0);
    end

    // Normal fetch after reset, two BUSY cycles
    access(1'b1, 1'b0, 1'b0, 32'h600, 32'h0, 32'h0, 32'h0BADF00D, ACC, 2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
